// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection and a saturating
// counter of the bubbles inserted for load-use stalls.
module id_ex_stage_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [3:0]       id_inst4,
    input  logic [1:0]       id_aluop,
    input  logic             id_alusrc,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             id_regwrite,
    input  logic             id_memtoreg,
    input  logic             id_branch,
    input  logic             hold_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [3:0]       ex_inst4,
    output logic [1:0]       ex_aluop,
    output logic             ex_alusrc,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_regwrite,
    output logic             ex_memtoreg,
    output logic             ex_branch,
    output logic [CNT_W-1:0] bubble_cnt
);

    // Single-bit control flags packed {alusrc, memread, memwrite, regwrite, memtoreg, branch}
    logic [5:0]       ctrl_q, ctrl_d;
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    logic [4:0]       rs1_q, rs1_d;
    logic [4:0]       rs2_q, rs2_d;
    logic [4:0]       rd_q, rd_d;
    logic [3:0]       inst4_q, inst4_d;
    logic [1:0]       aluop_q, aluop_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic             lu;

    // Load-use detection: a load in EX whose destination the ID instruction reads.
    // Uses only registered EX state plus ID inputs, so reset drops it at once.
    always_comb begin
        lu = valid_q & ctrl_q[4] & (rd_q != 5'd0) & id_valid &
             ((id_use_rs1 & (id_rs1 == rd_q)) | (id_use_rs2 & (id_rs2 == rd_q)));
        stall_o = lu & ~flush_i & ~hold_i;
    end

    // Next-state: flush beats hold beats load-use beats a normal load.
    always_comb begin
        valid_d      = valid_q;
        pc_d         = pc_q;
        rs1_data_d   = rs1_data_q;
        rs2_data_d   = rs2_data_q;
        imm_d        = imm_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        inst4_d      = inst4_q;
        aluop_d      = aluop_q;
        ctrl_d       = ctrl_q;
        bubble_cnt_d = bubble_cnt_q;
        if (flush_i || (!hold_i && lu)) begin
            // Bubble: kill control, leave data fields untouched
            valid_d = 1'b0;
            ctrl_d  = 6'd0;
            aluop_d = 2'b00;
            inst4_d = 4'd0;
            rd_d    = 5'd0;
            if (!flush_i && bubble_cnt_q != {CNT_W{1'b1}}) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end else if (!hold_i) begin
            valid_d    = id_valid;
            pc_d       = id_pc;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rd_d       = id_rd;
            inst4_d    = id_inst4;
            aluop_d    = id_aluop & {2{id_valid}};
            ctrl_d     = {id_alusrc, id_memread, id_memwrite,
                          id_regwrite, id_memtoreg, id_branch} & {6{id_valid}};
        end
    end

    // Pipeline register state with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            inst4_q      <= '0;
            aluop_q      <= '0;
            ctrl_q       <= '0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
            imm_q        <= imm_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            inst4_q      <= inst4_d;
            aluop_q      <= aluop_d;
            ctrl_q       <= ctrl_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_pc       = pc_q;
    assign ex_rs1_data = rs1_data_q;
    assign ex_rs2_data = rs2_data_q;
    assign ex_imm      = imm_q;
    assign ex_rs1      = rs1_q;
    assign ex_rs2      = rs2_q;
    assign ex_rd       = rd_q;
    assign ex_inst4    = inst4_q;
    assign ex_aluop    = aluop_q;
    assign ex_alusrc   = ctrl_q[5];
    assign ex_memread  = ctrl_q[4];
    assign ex_memwrite = ctrl_q[3];
    assign ex_regwrite = ctrl_q[2];
    assign ex_memtoreg = ctrl_q[1];
    assign ex_branch   = ctrl_q[0];
    assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg (built with CNT_W=2 to reach saturation quickly).
module tb_id_ex_stage_reg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid;
    logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             id_use_rs1, id_use_rs2;
    logic [3:0]       id_inst4;
    logic [1:0]       id_aluop;
    logic             id_alusrc, id_memread, id_memwrite, id_regwrite, id_memtoreg, id_branch;
    logic             hold_i, flush_i;
    logic             stall_o, ex_valid;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [3:0]       ex_inst4;
    logic [1:0]       ex_aluop;
    logic             ex_alusrc, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg, ex_branch;
    logic [CNT_W-1:0] bubble_cnt;

    int checks   = 0;
    int failures = 0;

    // Control encodings {alusrc, memread, memwrite, regwrite, memtoreg, branch}
    localparam logic [5:0] C_ALU = 6'b000100;
    localparam logic [5:0] C_LW  = 6'b110110;
    localparam logic [5:0] C_BR  = 6'b000001;

    id_ex_stage_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_inst4(id_inst4), .id_aluop(id_aluop),
        .id_alusrc(id_alusrc), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .id_branch(id_branch),
        .hold_i(hold_i), .flush_i(flush_i), .stall_o(stall_o), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_inst4(ex_inst4), .ex_aluop(ex_aluop),
        .ex_alusrc(ex_alusrc), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] ex_ctrl();
        return {ex_alusrc, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg, ex_branch};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                          input logic u2, input logic [3:0] i4, input logic [1:0] op,
                          input logic [5:0] c);
        id_valid    = v;
        id_pc       = pc;
        id_rs1_data = pc ^ 32'hA5A5_0000;
        id_rs2_data = pc ^ 32'h0000_5A5A;
        id_imm      = pc + 32'd4;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        id_inst4    = i4;
        id_aluop    = op;
        {id_alusrc, id_memread, id_memwrite, id_regwrite, id_memtoreg, id_branch} = c;
    endtask

    initial begin
        int exp_cnt;
        rst_n = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
        set_id(1'b1, 32'h0000_0050, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 4'b0111, 2'b10, C_LW);
        tick(); tick();
        chk("reset_valid", 32'(ex_valid), 32'd0);
        chk("reset_aluop", 32'(ex_aluop), 32'd0);
        chk("reset_pc", ex_pc, 32'd0);
        chk("reset_ctrl", 32'(ex_ctrl()), 32'd0);
        chk("reset_cnt", 32'(bubble_cnt), 32'd0);
        chk("reset_stall", 32'(stall_o), 32'd0);
        rst_n = 1'b1;

        // Straight-line ADD then SUB
        set_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 4'b0000, 2'b10, C_ALU);
        #1 chk("add_stall", 32'(stall_o), 32'd0);
        tick();
        chk("add_inst4", 32'(ex_inst4), 32'h0);
        chk("add_aluop", 32'(ex_aluop), 32'h2);
        chk("add_pc", ex_pc, 32'h100);
        chk("add_rs1_data", ex_rs1_data, 32'hA5A5_0100);
        chk("add_rd", 32'(ex_rd), 32'd3);
        chk("add_ctrl", 32'(ex_ctrl()), 32'(C_ALU));
        set_id(1'b1, 32'h104, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 4'b1000, 2'b10, C_ALU);
        #1 chk("sub_stall", 32'(stall_o), 32'd0);
        tick();
        chk("sub_inst4", 32'(ex_inst4), 32'h8);
        chk("sub_aluop", 32'(ex_aluop), 32'h2);
        chk("sub_pc", ex_pc, 32'h104);

        // Load-use: lw x5 then add reading x5
        set_id(1'b1, 32'h108, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 4'b0010, 2'b00, C_LW);
        tick();
        chk("lw_memread", 32'(ex_memread), 32'd1);
        set_id(1'b1, 32'h10C, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 4'b0000, 2'b10, C_ALU);
        #1 chk("lu_stall", 32'(stall_o), 32'd1);
        tick();
        chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu_bubble_aluop", 32'(ex_aluop), 32'd0);
        chk("lu_bubble_ctrl", 32'(ex_ctrl()), 32'd0);
        chk("lu_bubble_rd", 32'(ex_rd), 32'd0);
        chk("lu_cnt", 32'(bubble_cnt), 32'd1);
        chk("lu_stall_clears", 32'(stall_o), 32'd0);
        tick();
        chk("lu_add_valid", 32'(ex_valid), 32'd1);
        chk("lu_add_pc", ex_pc, 32'h10C);
        chk("lu_add_rd", 32'(ex_rd), 32'd7);
        chk("lu_add_cnt", 32'(bubble_cnt), 32'd1);

        // No false hazard: load to x0
        set_id(1'b1, 32'h110, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 4'b0010, 2'b00, C_LW);
        tick();
        set_id(1'b1, 32'h114, 5'd0, 5'd6, 5'd8, 1'b1, 1'b1, 4'b0000, 2'b10, C_ALU);
        #1 chk("x0_stall", 32'(stall_o), 32'd0);
        tick();
        chk("x0_valid", 32'(ex_valid), 32'd1);
        chk("x0_pc", ex_pc, 32'h114);
        // No false hazard: matching rs1 not used
        set_id(1'b1, 32'h118, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 4'b0010, 2'b00, C_LW);
        tick();
        set_id(1'b1, 32'h11C, 5'd5, 5'd6, 5'd8, 1'b0, 1'b1, 4'b0001, 2'b10, C_ALU);
        #1 chk("nouse_stall", 32'(stall_o), 32'd0);
        tick();
        chk("nouse_pc", ex_pc, 32'h11C);
        chk("nouse_cnt", 32'(bubble_cnt), 32'd1);

        // Flush wins over hold and load-use
        set_id(1'b1, 32'h120, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 4'b0010, 2'b00, C_LW);
        tick();
        set_id(1'b1, 32'h124, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 4'b0000, 2'b10, C_ALU);
        #1 chk("pre_flush_stall", 32'(stall_o), 32'd1);
        flush_i = 1'b1; hold_i = 1'b1;
        #1 chk("flush_stall", 32'(stall_o), 32'd0);
        tick();
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_regwrite", 32'(ex_regwrite), 32'd0);
        chk("flush_cnt", 32'(bubble_cnt), 32'd1);
        flush_i = 1'b0; hold_i = 1'b0;
        tick();
        chk("post_flush_pc", ex_pc, 32'h124);
        chk("post_flush_valid", 32'(ex_valid), 32'd1);

        // Hold for three cycles while ID changes
        hold_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_id(1'b1, 32'h200 + 32'(4 * k), 5'd9, 5'd10, 5'd9, 1'b1, 1'b1, 4'b0101, 2'b01, C_BR);
            tick();
            chk("hold_pc", ex_pc, 32'h124);
            chk("hold_rd", 32'(ex_rd), 32'd7);
            chk("hold_aluop", 32'(ex_aluop), 32'h2);
            chk("hold_ctrl", 32'(ex_ctrl()), 32'(C_ALU));
        end
        hold_i = 1'b0;
        set_id(1'b1, 32'h20C, 5'd9, 5'd10, 5'd9, 1'b1, 1'b1, 4'b0101, 2'b01, C_BR);
        tick();
        chk("release_pc", ex_pc, 32'h20C);
        chk("release_inst4", 32'(ex_inst4), 32'h5);
        chk("release_aluop", 32'(ex_aluop), 32'h1);
        chk("release_ctrl", 32'(ex_ctrl()), 32'(C_BR));
        chk("release_rd", 32'(ex_rd), 32'd9);

        // Invalid ID slot: controls forced to zero, data captured
        set_id(1'b0, 32'h300, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 4'b0000, 2'b10, C_LW);
        tick();
        chk("inval_valid", 32'(ex_valid), 32'd0);
        chk("inval_ctrl", 32'(ex_ctrl()), 32'd0);
        chk("inval_aluop", 32'(ex_aluop), 32'd0);
        chk("inval_pc", ex_pc, 32'h300);

        // Five more load-use bubbles: count saturates at 3
        exp_cnt = 1;
        for (int k = 0; k < 5; k++) begin
            set_id(1'b1, 32'h400 + 32'(16 * k), 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 4'b0010, 2'b00, C_LW);
            tick();
            set_id(1'b1, 32'h404 + 32'(16 * k), 5'd1, 5'd5, 5'd7, 1'b1, 1'b1, 4'b0000, 2'b10, C_ALU);
            #1 chk("sat_stall", 32'(stall_o), 32'd1);
            tick();
            tick();
            exp_cnt = (exp_cnt == 3) ? 3 : exp_cnt + 1;
            chk("sat_cnt", 32'(bubble_cnt), 32'(exp_cnt));
        end
        chk("sat_final", 32'(bubble_cnt), 32'd3);

        // Asynchronous reset in the middle of a stall cycle
        set_id(1'b1, 32'h500, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 4'b0010, 2'b00, C_LW);
        tick();
        set_id(1'b1, 32'h504, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 4'b0000, 2'b10, C_ALU);
        #1 chk("arst_pre_stall", 32'(stall_o), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_stall", 32'(stall_o), 32'd0);
        chk("arst_valid", 32'(ex_valid), 32'd0);
        chk("arst_pc", ex_pc, 32'd0);
        chk("arst_rd", 32'(ex_rd), 32'd0);
        chk("arst_ctrl", 32'(ex_ctrl()), 32'd0);
        chk("arst_cnt", 32'(bubble_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
